stdp_array: RTL and testbench

// - N_SYN-synapse STDP learning block with one shared post-synaptic neuron; successor to the single-synapse LTP-only block.
// - Per-synapse pre-spike timers and one shared post-spike timer. LTP on post spikes, LTD on pre spikes.
// - Each weight change is a shift-based exponential of spike-time distance, saturated to [W_MIN, W_MAX].
// - Sits between the spike-source front end and the neuron accumulator; also provides a host weight-write port.

---
 rtl/stdp_pkg.sv | 26 ++
 rtl/stdp_synapse.sv | 81 ++++++++
 rtl/stdp_array.sv | 80 ++++++++
 tb/tb_stdp_array.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared helpers for the STDP array: saturated-timer limit, exponential decay
// by shifting, and the weight clamp.
package stdp_pkg;

    // Saturation value of a tw-bit spike timer; this value marks "no recent spike".
    function automatic int unsigned t_max(int unsigned tw);
        if (tw >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << tw) - 32'd1;
    endfunction

    // Amplitude a halves every 2**tau_shift cycles of spike-time distance t.
    function automatic int unsigned delta(int unsigned t, int unsigned a,
                                          int unsigned tau_shift);
        int unsigned sh;
        sh = t >> tau_shift;
        if (sh >= 32) return 0;
        return a >> sh;
    endfunction

    function automatic int clamp(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One plastic synapse: pre-spike timer, weight register, LTP/LTD delta datapath
// with saturating net update, and the per-synapse update flags.
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter int unsigned WW        = 8,
    parameter int unsigned TW        = 8,
    parameter int unsigned W_INIT    = 64,
    parameter int          W_MIN     = 0,
    parameter int          W_MAX     = 255,
    parameter int unsigned A_PLUS    = 16,
    parameter int unsigned A_MINUS   = 8,
    parameter int unsigned TAU_SHIFT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pre_spike,
    input  logic          post_spike,
    input  logic [TW-1:0] post_t,
    input  logic          learn_en,
    input  logic          wr_en,
    input  logic [WW-1:0] wr_data,
    output logic [WW-1:0] weight,
    output logic          ltp_flag,
    output logic          ltd_flag
);

    localparam logic [TW-1:0] T_MAX = TW'(t_max(TW));

    logic [TW-1:0]        pre_t_q, pre_t_d;
    logic [WW-1:0]        weight_q, weight_d;
    logic                 ltp_q, ltp_d, ltd_q, ltd_d;
    logic                 ltp_hit, ltd_hit;
    logic signed [WW+1:0] p_amt, m_amt, sum;

    always_comb begin
        pre_t_d = pre_t_q;
        if (pre_spike) begin
            pre_t_d = '0;
        end else if (pre_t_q != T_MAX) begin
            pre_t_d = pre_t_q + TW'(1);
        end

        // Both directions read the timers as they stood before this edge.
        ltp_hit = learn_en && post_spike && (pre_t_q != T_MAX);
        ltd_hit = learn_en && pre_spike && (post_t != T_MAX);
        p_amt   = ltp_hit ? (WW+2)'(delta(32'(pre_t_q), A_PLUS, TAU_SHIFT)) : '0;
        m_amt   = ltd_hit ? (WW+2)'(delta(32'(post_t), A_MINUS, TAU_SHIFT)) : '0;
        sum     = $signed({2'b00, weight_q}) + p_amt - m_amt;

        weight_d = weight_q;
        ltp_d    = 1'b0;
        ltd_d    = 1'b0;
        if (wr_en) begin
            weight_d = wr_data;
        end else if (ltp_hit || ltd_hit) begin
            weight_d = WW'(clamp(int'(sum), W_MIN, W_MAX));
            ltp_d    = ltp_hit;
            ltd_d    = ltd_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_t_q  <= T_MAX;
            weight_q <= WW'(W_INIT);
            ltp_q    <= 1'b0;
            ltd_q    <= 1'b0;
        end else begin
            pre_t_q  <= pre_t_d;
            weight_q <= weight_d;
            ltp_q    <= ltp_d;
            ltd_q    <= ltd_d;
        end
    end

    assign weight   = weight_q;
    assign ltp_flag = ltp_q;
    assign ltd_flag = ltd_q;

endmodule

// File: rtl/stdp_array.sv
// N_SYN-synapse STDP block sharing one post-synaptic neuron: post-spike timer,
// host write decode and packing of the per-synapse weights onto a flat bus.
module stdp_array
    import stdp_pkg::*;
#(
    parameter int unsigned N_SYN     = 4,
    parameter int unsigned WW        = 8,
    parameter int unsigned TW        = 8,
    parameter int unsigned W_INIT    = 64,
    parameter int          W_MIN     = 0,
    parameter int          W_MAX     = 255,
    parameter int unsigned A_PLUS    = 16,
    parameter int unsigned A_MINUS   = 8,
    parameter int unsigned TAU_SHIFT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SYN-1:0]         pre_spike,
    input  logic                     post_spike,
    input  logic                     learn_en,
    input  logic                     wr_en,
    input  logic [$clog2(N_SYN)-1:0] wr_idx,
    input  logic [WW-1:0]            wr_data,
    output logic [N_SYN*WW-1:0]      weights,
    output logic [N_SYN-1:0]         ltp_flag,
    output logic [N_SYN-1:0]         ltd_flag
);

    localparam int unsigned   IW    = $clog2(N_SYN);
    localparam logic [TW-1:0] T_MAX = TW'(t_max(TW));

    logic [TW-1:0]    post_t_q, post_t_d;
    logic [N_SYN-1:0] wr_stb;

    always_comb begin
        post_t_d = post_t_q;
        if (post_spike) begin
            post_t_d = '0;
        end else if (post_t_q != T_MAX) begin
            post_t_d = post_t_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_t_q <= T_MAX;
        end else begin
            post_t_q <= post_t_d;
        end
    end

    for (genvar i = 0; i < N_SYN; i++) begin : g_syn
        // Out-of-range indices match no synapse, so such writes are dropped.
        assign wr_stb[i] = wr_en && (wr_idx == IW'(i));

        stdp_synapse #(
            .WW       (WW),
            .TW       (TW),
            .W_INIT   (W_INIT),
            .W_MIN    (W_MIN),
            .W_MAX    (W_MAX),
            .A_PLUS   (A_PLUS),
            .A_MINUS  (A_MINUS),
            .TAU_SHIFT(TAU_SHIFT)
        ) u_syn (
            .clk       (clk),
            .rst_n     (rst_n),
            .pre_spike (pre_spike[i]),
            .post_spike(post_spike),
            .post_t    (post_t_q),
            .learn_en  (learn_en),
            .wr_en     (wr_stb[i]),
            .wr_data   (wr_data),
            .weight    (weights[i*WW +: WW]),
            .ltp_flag  (ltp_flag[i]),
            .ltd_flag  (ltd_flag[i])
        );
    end

endmodule

// File: tb/tb_stdp_array.sv
// Self-checking bench for stdp_array: directed scenarios plus randomized spike
// traffic compared against a behavioural STDP model.
module tb_stdp_array;

    localparam int N    = 4;
    localparam int WW   = 8;
    localparam int TMAX = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    pre_spike = '0;
    logic            post_spike = 1'b0;
    logic            learn_en = 1'b1;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_idx = '0;
    logic [WW-1:0]   wr_data = '0;
    logic [N*WW-1:0] weights;
    logic [N-1:0]    ltp_flag, ltd_flag;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           m_w[N];
    int           m_pre_t[N];
    int           m_post_t;
    logic [N-1:0] m_ltp, m_ltd;

    always #5 clk = ~clk;

    stdp_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pre_spike (pre_spike),
        .post_spike(post_spike),
        .learn_en  (learn_en),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .weights   (weights),
        .ltp_flag  (ltp_flag),
        .ltd_flag  (ltd_flag)
    );

    // Exponential decay: amplitude divided by 2 for every 4 cycles of distance.
    function automatic int decay(int t, int a);
        int halvings = t / 4;
        if (halvings >= 31) return 0;
        return a / (1 << halvings);
    endfunction

    function automatic int w_of(int i);
        return int'(weights[i*WW +: WW]);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_w[i] = 64;
                m_pre_t[i] = TMAX;
            end
            m_post_t = TMAX;
            m_ltp = '0;
            m_ltd = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            int p = 0;
            int m = 0;
            int nw;
            m_ltp[i] = 1'b0;
            m_ltd[i] = 1'b0;
            if (learn_en && post_spike && m_pre_t[i] < TMAX) begin
                p = decay(m_pre_t[i], 16);
                m_ltp[i] = 1'b1;
            end
            if (learn_en && pre_spike[i] && m_post_t < TMAX) begin
                m = decay(m_post_t, 8);
                m_ltd[i] = 1'b1;
            end
            nw = m_w[i] + p - m;
            if (nw < 0) nw = 0;
            if (nw > 255) nw = 255;
            if (wr_en && int'(wr_idx) == i) begin
                nw = int'(wr_data);
                m_ltp[i] = 1'b0;
                m_ltd[i] = 1'b0;
            end
            m_w[i] = nw;
        end
        for (int i = 0; i < N; i++)
            m_pre_t[i] = pre_spike[i] ? 0 : (m_pre_t[i] < TMAX ? m_pre_t[i] + 1 : TMAX);
        m_post_t = post_spike ? 0 : (m_post_t < TMAX ? m_post_t + 1 : TMAX);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, sample 1 after it.
    task automatic step(input logic [N-1:0] pre, input logic post, input logic we = 1'b0,
                        input int idx = 0, input int data = 0);
        pre_spike  = pre;
        post_spike = post;
        wr_en      = we;
        wr_idx     = 2'(idx);
        wr_data    = 8'(data);
        @(posedge clk);
        model_edge();
        #1;
        pre_spike  = '0;
        post_spike = 1'b0;
        wr_en      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (w_of(i) !== 64) begin
                n_errors++;
                $display("FAIL reset_weight[%0d]: got %0d expected 64", i, w_of(i));
            end
        end
        n_checks++;
        if (ltp_flag !== 4'b0000 || ltd_flag !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got ltp=%b ltd=%b expected 0000/0000", ltp_flag, ltd_flag);
        end
        rst_n = 1'b1;
        step(4'b0000, 1'b1);
        n_checks++;
        if (ltp_flag !== 4'b0000 || weights !== {4{8'd64}}) begin
            n_errors++;
            $display("FAIL reset_post_no_pre: got ltp=%b w=%h expected 0000 / all 40", ltp_flag,
                     weights);
        end
    endtask

    task automatic test_ltp();
        do_reset();
        step(4'b0001, 1'b0);
        repeat (4) step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        n_checks++;
        if (w_of(0) !== 72 || ltp_flag !== 4'b0001 || ltd_flag !== 4'b0000) begin
            n_errors++;
            $display("FAIL ltp_dt4: got w0=%0d ltp=%b ltd=%b expected 72 0001 0000", w_of(0),
                     ltp_flag, ltd_flag);
        end
        step(4'b0000, 1'b0);
        n_checks++;
        if (w_of(0) !== 72 || ltp_flag !== 4'b0000) begin
            n_errors++;
            $display("FAIL ltp_pulse_end: got w0=%0d ltp=%b expected 72 0000", w_of(0), ltp_flag);
        end
    endtask

    task automatic test_ltd();
        do_reset();
        step(4'b0000, 1'b1);
        repeat (2) step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        n_checks++;
        if (w_of(1) !== 56 || ltd_flag !== 4'b0010 || ltp_flag !== 4'b0000) begin
            n_errors++;
            $display("FAIL ltd_dt2: got w1=%0d ltd=%b ltp=%b expected 56 0010 0000", w_of(1),
                     ltd_flag, ltp_flag);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        step(4'b0000, 1'b0, 1'b1, 2, 250);
        n_checks++;
        if (w_of(2) !== 250) begin
            n_errors++;
            $display("FAIL host_write_w2: got %0d expected 250", w_of(2));
        end
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        n_checks++;
        if (w_of(2) !== 255 || ltp_flag !== 4'b0100) begin
            n_errors++;
            $display("FAIL clamp_high: got w2=%0d ltp=%b expected 255 0100", w_of(2), ltp_flag);
        end
        step(4'b0000, 1'b0, 1'b1, 3, 3);
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        n_checks++;
        if (w_of(3) !== 0 || ltd_flag !== 4'b1000) begin
            n_errors++;
            $display("FAIL clamp_low: got w3=%0d ltd=%b expected 0 1000", w_of(3), ltd_flag);
        end
    endtask

    task automatic test_override();
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 0, 8'hA5);
        n_checks++;
        if (w_of(0) !== 8'hA5 || ltp_flag[0] !== 1'b0 || ltd_flag[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL write_override: got w0=%h ltp0=%b ltd0=%b expected a5 0 0", w_of(0),
                     ltp_flag[0], ltd_flag[0]);
        end
    endtask

    task automatic test_gate();
        do_reset();
        learn_en = 1'b0;
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b1);
        n_checks++;
        if (ltp_flag !== 4'b0000 || weights !== {4{8'd64}}) begin
            n_errors++;
            $display("FAIL gate_post: got ltp=%b w=%h expected 0000 / all 40", ltp_flag, weights);
        end
        step(4'b0010, 1'b0);
        n_checks++;
        if (ltd_flag !== 4'b0000 || weights !== {4{8'd64}}) begin
            n_errors++;
            $display("FAIL gate_pre: got ltd=%b w=%h expected 0000 / all 40", ltd_flag, weights);
        end
        step(4'b0000, 1'b0, 1'b1, 3, 8'h11);
        n_checks++;
        if (w_of(3) !== 8'h11) begin
            n_errors++;
            $display("FAIL gate_write: got w3=%h expected 11", w_of(3));
        end
        learn_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        n_checks++;
        if (w_of(0) !== 72 || ltd_flag !== 4'b0001) begin
            n_errors++;
            $display("FAIL pre_after_post: got w0=%0d ltd=%b expected 72 0001", w_of(0), ltd_flag);
        end
        rst_n = 1'b0;
        step(4'b0000, 1'b0);
        rst_n = 1'b1;
        n_checks++;
        if (weights !== {4{8'd64}} || ltd_flag !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_mid: got w=%h ltd=%b expected all 40 / 0000", weights, ltd_flag);
        end
        step(4'b0000, 1'b1);
        n_checks++;
        if (w_of(0) !== 64 || ltp_flag !== 4'b0000) begin
            n_errors++;
            $display("FAIL post_after_reset: got w0=%0d ltp=%b expected 64 0000", w_of(0),
                     ltp_flag);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [N-1:0] pre;
            logic         post;
            for (int i = 0; i < N; i++) pre[i] = ($urandom_range(0, 5) == 0);
            post     = ($urandom_range(0, 4) == 0);
            rst_n    = ($urandom_range(0, 149) != 0);
            learn_en = ($urandom_range(0, 9) != 0);
            step(pre, post, ($urandom_range(0, 11) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)));
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (w_of(i) !== m_w[i]) begin
                    n_errors++;
                    $display("FAIL rand_weight[%0d] cycle %0d: got %0d expected %0d", i, n,
                             w_of(i), m_w[i]);
                end
            end
            n_checks++;
            if (ltp_flag !== m_ltp || ltd_flag !== m_ltd) begin
                n_errors++;
                $display("FAIL rand_flags cycle %0d: got ltp=%b ltd=%b expected %b %b", n,
                         ltp_flag, ltd_flag, m_ltp, m_ltd);
            end
        end
        rst_n    = 1'b1;
        learn_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ltp();
        test_ltd();
        test_clamp();
        test_override();
        test_gate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
